serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
Sequencer for a bit-serial add/subtract datapath built from two right-shifting operand registers, a carry flip-flop and a result shift register. On a start request it loads parallel operands A and B. It then clocks the shift registers for WIDTH cycles, one full-adder bit per cycle, LSB first. It presents the registered result with a one-cycle done pulse. It sits between a parallel producer and the shift-register datapath and owns all load/shift sequencing.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)
CW, 3, counter width; must satisfy 2**CW >= WIDTH

Ports:
clk    input   1      rising-edge clock
reset  input   1      asynchronous, active-low reset (0 = reset asserted)
start  input   1      request; sampled only in IDLE
sub    input   1      0 = A+B, 1 = A-B; latched with operands at start
A      input   WIDTH  operand A, captured at start
B      input   WIDTH  operand B, captured at start
busy   output  1      high in SHIFT and DONE
done   output  1      one-cycle pulse, high in DONE
sum    output  WIDTH  registered result, held until next completion
cout   output  1      add: carry out; sub: 1 = no borrow (A >= B unsigned)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; counter, operand registers, carry, result register, sum and cout = 0; busy=0, done=0. Takes effect immediately, including mid-operation; a partial result is discarded.
- FSM states: IDLE, SHIFT, DONE. Outputs are Moore-decoded from state.
- IDLE:
  - start=1 at edge E0 loads sa<=A and sb<=(sub ? ~B : B).
  - The same edge sets carry<=sub, cnt<=0 and moves to SHIFT.
  - start=0: remain in IDLE; all registers hold.
- SHIFT, each edge:
  - s = sa[0]^sb[0]^carry.
  - carry<=majority(sa[0],sb[0],carry).
  - sa, sb shift right (MSB filled 0); res<={s,res[WIDTH-1:1]}; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH): sum<={s,res[WIDTH-1:1]}, cout<=majority(...), next state DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - done rises at edge E_WIDTH, i.e. WIDTH clocks after the start-sampling edge.
  - busy rises at E0 and falls at E_WIDTH+1.
  - Minimum start-to-start throughput: WIDTH+2 cycles.
- Arithmetic: modulo 2**WIDTH, unsigned. Subtraction is A + ~B + 1.
- sum and cout change only at edge E_WIDTH. They are stable throughout SHIFT, DONE and subsequent IDLE.
- start while busy (SHIFT or DONE) is ignored, with no queuing. If start is still high in the IDLE cycle after DONE, a new operation begins on that edge (back-to-back).
- Changes to A, B or sub after E0 have no effect on the operation in flight.
- Counter never wraps: it is cleared at E0 and stops at WIDTH-1.

Test Plan:
1. WIDTH=4, reset low then released. A=0101, B=0111, sub=0, start pulse one cycle -> busy=1 from next edge; done pulse exactly 4 edges after the start edge; sum=1100, cout=0; busy=0 one cycle later.
2. A=0101, B=0111, sub=1 -> sum=1110 (5-7 mod 16), cout=0. Then A=0111, B=0101, sub=1 -> sum=0010, cout=1.
3. A=1111, B=0001, sub=0 -> sum=0000, cout=1. Then A=0000, B=0000 -> sum=0000, cout=0.
4. Drive reset=0 two edges into SHIFT -> busy, done, sum, cout = 0 immediately, without waiting for a clock. After release, with start=0, stay IDLE and no done pulse.
5. Pulse start again during SHIFT, and change A/B/sub mid-operation -> ignored; result matches the operands captured at E0; exactly one done pulse.
6. Hold start=1 continuously with A=0011, B=0001 -> done pulses every 6 cycles, sum=0100 each time. sum holds unchanged between pulses.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Sequencer for a bit-serial add/subtract datapath, one full-adder bit per clock, LSB first.
// Latency: done pulses WIDTH clocks after the start-sampling edge; start-to-start >= WIDTH+2 clocks.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
module serial_addsub_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;

  logic             load;
  logic             shift;
  logic             last;
  logic             bit_s;
  logic             bit_c;

  // Full adder on the current LSBs of the operand shift registers.
  assign bit_s = sa[0] ^ sb[0] ^ carry;
  assign bit_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign last  = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at load and seed the carry with sub.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      sa    <= A;
      sb    <= sub ? ~B : B;
      carry <= sub;
      cnt   <= '0;
    end else if (shift) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      res   <= {bit_s, res[WIDTH-1:1]};
      carry <= bit_c;
      if (!last) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Published result only moves on the final bit, so it is stable across later operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (shift && last) begin
      sum  <= {bit_s, res[WIDTH-1:1]};
      cout <= bit_c;
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: arithmetic reference model, randomized operands and mid-flight noise.
module tb_serial_addsub_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           cyc;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           cyc     = 0;
  int           tests   = 0;
  int           fails   = 0;
  int           busy_lo = 0;
  int           busy_hi = -1;
  int           next_ok = 0;
  logic [W-1:0] held_s  = '0;
  logic         held_c  = 1'b0;
  exp_t         q[$];
  exp_t         mon_e;

  serial_addsub_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain modular arithmetic; cout is carry-out for add, "no borrow" for subtract.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int done_cyc);
    exp_t r;
    int   t;
    if (!s) begin
      t   = int'(a) + int'(b);
      r.s = W'(t % (1 << W));
      r.c = (t >= (1 << W));
    end else begin
      t   = int'(a) - int'(b);
      r.s = W'((t + (1 << W)) % (1 << W));
      r.c = (a >= b);
    end
    r.cyc = done_cyc;
    return r;
  endfunction

  // mode 0: drop start after E0; 1: random start/operand noise while busy; 2: hold start and operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int mode);
    int c0;
    while (cyc + 1 < next_ok) @(negedge clk);
    A     = a;
    B     = b;
    sub   = s;
    start = 1'b1;
    c0    = cyc + 1;
    q.push_back(model(a, b, s, c0 + W));
    busy_lo = c0;
    busy_hi = c0 + W;
    next_ok = c0 + W + 2;
    @(negedge clk);
    while (cyc + 1 <= c0 + W + 1) begin
      if (mode == 0) begin
        start = 1'b0;
      end else if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        A     = W'($urandom_range(0, (1 << W) - 1));
        B     = W'($urandom_range(0, (1 << W) - 1));
        sub   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    if (mode != 2) start = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks busy window and result holding otherwise.
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("sum", {28'd0, sum}, {28'd0, mon_e.s});
          chk("cout", {31'd0, cout}, {31'd0, mon_e.c});
          held_s = mon_e.s;
          held_c = mon_e.c;
        end
      end else begin
        if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("done_timeout", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        chk("sum_hold", {28'd0, sum}, {28'd0, held_s});
        chk("cout_hold", {31'd0, cout}, {31'd0, held_c});
      end
    end
  end

  initial begin
    int c0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {28'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    next_ok = cyc + 1;
    repeat (2) @(negedge clk);

    issue(4'b0101, 4'b0111, 1'b0, 0);
    issue(4'b0101, 4'b0111, 1'b1, 0);
    issue(4'b0111, 4'b0101, 1'b1, 0);
    issue(4'b1111, 4'b0001, 1'b0, 0);
    issue(4'b0000, 4'b0000, 1'b0, 0);
    issue(4'b1001, 4'b1000, 1'b0, 0);

    // Asynchronous reset two edges into SHIFT; the partial result must vanish.
    while (cyc + 1 < next_ok) @(negedge clk);
    A       = 4'b0110;
    B       = 4'b0011;
    start   = 1'b1;
    c0      = cyc + 1;
    busy_lo = c0;
    busy_hi = c0 + W;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    held_s  = '0;
    held_c  = 1'b0;
    busy_hi = -1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {28'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    next_ok = cyc + 1;
    repeat (4) @(negedge clk);

    issue(4'b0110, 4'b0011, 1'b1, 1);
    issue(4'b1010, 4'b1100, 1'b0, 1);

    for (int i = 0; i < 5; i++) issue(4'b0011, 4'b0001, 1'b0, 2);
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        A = W'($urandom_range(0, (1 << W) - 1));
        B = W'($urandom_range(0, (1 << W) - 1));
      end
      issue(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)) % 2);
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
